seq_pattern_gen: RTL and testbench

Serial test-pattern transmitter that drives a single-bit stream into the team's serial sequence detectors (e.g. the "101" detectors). On a start pulse it captures a WIDTH-bit pattern, a repetition count and an inter-frame gap. It then shifts the pattern out MSB-first, one bit per clock, with a valid qualifier, for the requested number of frames, and signals completion with a one-cycle pulse. It sits on the stimulus side of the detector blocks and serves as the standard source for their integration benches.

---
 rtl/seq_pkg.sv | 46 ++++
 rtl/seq_down_counter.sv | 40 ++++
 rtl/seq_pattern_gen.sv | 213 +++++++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the serial pattern generator and the benches of the
// sequence detectors it feeds.
//   - state encoding constants and the FSM state type
//   - default pattern loaded at reset
//   - frame-length helpers for computing run lengths
// -----------------------------------------------------------------------------
package seq_pkg;

    // State encoding
    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_SEND = 2'd1;
    localparam logic [1:0] STATE_GAP  = 2'd2;

    typedef enum logic [1:0] {
        StIdle = STATE_IDLE,
        StSend = STATE_SEND,
        StGap  = STATE_GAP
    } seq_state_e;

    // Pattern register contents after reset
    localparam logic [2:0] SEQ_DEFAULT_PAT = 3'b101;

    // A repetition count of zero is treated as a single frame
    function automatic int unsigned eff_reps(input int unsigned reps);
        return (reps == 0) ? 1 : reps;
    endfunction

    // Number of cycles with busy=1 for one run
    function automatic int unsigned busy_cycles(input int unsigned width,
                                                input int unsigned reps,
                                                input int unsigned gap);
        int unsigned r;
        r = eff_reps(reps);
        return r * width + (r - 1) * gap;
    endfunction

    // Cycles from the first bit up to and including the done pulse
    function automatic int unsigned run_cycles(input int unsigned width,
                                               input int unsigned reps,
                                               input int unsigned gap);
        return busy_cycles(width, reps, gap) + 1;
    endfunction

endpackage

// File: rtl/seq_down_counter.sv
// -----------------------------------------------------------------------------
// seq_down_counter
// Loadable down-counter with a zero flag. Decrement saturates at zero.
// Ports:
//   clk      - clock
//   rst      - asynchronous active-high reset, clears the count
//   load     - load load_val (takes priority over dec)
//   dec      - decrement by one when non-zero
//   load_val - value to load
//   count    - current count
//   zero     - count == 0
// -----------------------------------------------------------------------------
module seq_down_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// -----------------------------------------------------------------------------
// seq_pattern_gen
// Serial test-pattern transmitter. On start it captures a WIDTH-bit pattern,
// a repetition count and an inter-frame gap, then shifts the pattern out
// MSB-first for the requested number of frames and pulses done.
// Ports:
//   clk         - clock, all state on rising edge
//   rst         - asynchronous active-high reset
//   start       - run request, sampled only while idle
//   stop        - synchronous abort, sampled only while busy
//   pattern     - frame bits, MSB sent first
//   reps        - number of frames (0 treated as 1)
//   gap         - idle cycles between frames
//   dout        - serial bit, 0 whenever dout_valid=0
//   dout_valid  - dout carries a pattern bit
//   frame_start - first bit of a frame
//   busy        - high from the first bit through the last bit
//   done        - one-cycle pulse after the final bit
// -----------------------------------------------------------------------------
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int unsigned       WIDTH       = 3,
    parameter int unsigned       CNTW        = 8,
    parameter int unsigned       GAPW        = 4,
    parameter logic [WIDTH-1:0]  DEFAULT_PAT = WIDTH'(SEQ_DEFAULT_PAT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNTW-1:0]  reps,
    input  logic [GAPW-1:0]  gap,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDXW = $clog2(WIDTH);

    seq_state_e state_q, state_d;

    logic [WIDTH-1:0] pat_q, pat_d;
    logic [GAPW-1:0]  gap_len_q, gap_len_d;

    // Registered outputs
    logic dout_d, dout_valid_d, frame_start_d, busy_d, done_d;

    // Bit index: holds the index of the bit currently on dout
    logic            idx_load, idx_dec, idx_zero;
    logic [IDXW-1:0] idx_val, idx_cnt;

    // Frames still to send after the current one
    logic            frm_load, frm_dec, frm_zero;
    logic [CNTW-1:0] frm_val, frm_cnt;

    // Gap cycles still to spend after the current one
    logic            gcnt_load, gcnt_dec, gcnt_zero;
    logic [GAPW-1:0] gcnt_val, gcnt_cnt;

    logic unused_cnt;
    assign unused_cnt = ^{frm_cnt, gcnt_cnt};

    seq_down_counter #(
        .WIDTH (IDXW)
    ) u_idx_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (idx_load),
        .dec      (idx_dec),
        .load_val (idx_val),
        .count    (idx_cnt),
        .zero     (idx_zero)
    );

    seq_down_counter #(
        .WIDTH (CNTW)
    ) u_frm_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (frm_load),
        .dec      (frm_dec),
        .load_val (frm_val),
        .count    (frm_cnt),
        .zero     (frm_zero)
    );

    seq_down_counter #(
        .WIDTH (GAPW)
    ) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (gcnt_load),
        .dec      (gcnt_dec),
        .load_val (gcnt_val),
        .count    (gcnt_cnt),
        .zero     (gcnt_zero)
    );

    // Next-state logic. Outputs are computed for the cycle after the edge, so
    // the first bit appears in the same cycle the FSM enters SEND.
    always_comb begin
        state_d       = state_q;
        pat_d         = pat_q;
        gap_len_d     = gap_len_q;
        idx_load      = 1'b0;
        idx_dec       = 1'b0;
        idx_val       = IDXW'(WIDTH - 1);
        frm_load      = 1'b0;
        frm_dec       = 1'b0;
        frm_val       = '0;
        gcnt_load     = 1'b0;
        gcnt_dec      = 1'b0;
        gcnt_val      = '0;
        dout_d        = 1'b0;
        dout_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pat_d         = pattern;
                    gap_len_d     = gap;
                    frm_load      = 1'b1;
                    frm_val       = (reps == '0) ? '0 : reps - CNTW'(1);
                    idx_load      = 1'b1;
                    state_d       = StSend;
                    dout_d        = pattern[WIDTH-1];
                    dout_valid_d  = 1'b1;
                    frame_start_d = 1'b1;
                    busy_d        = 1'b1;
                end
            end

            StSend: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (!idx_zero) begin
                    idx_dec      = 1'b1;
                    dout_d       = pat_q[idx_cnt - IDXW'(1)];
                    dout_valid_d = 1'b1;
                    busy_d       = 1'b1;
                end else if (frm_zero) begin
                    // Last bit of the last frame
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    frm_dec = 1'b1;
                    busy_d  = 1'b1;
                    if (gap_len_q != '0) begin
                        state_d   = StGap;
                        gcnt_load = 1'b1;
                        gcnt_val  = gap_len_q - GAPW'(1);
                    end else begin
                        idx_load      = 1'b1;
                        dout_d        = pat_q[WIDTH-1];
                        dout_valid_d  = 1'b1;
                        frame_start_d = 1'b1;
                    end
                end
            end

            StGap: begin
                if (stop) begin
                    state_d = StIdle;
                end else begin
                    busy_d = 1'b1;
                    if (gcnt_zero) begin
                        state_d       = StSend;
                        idx_load      = 1'b1;
                        dout_d        = pat_q[WIDTH-1];
                        dout_valid_d  = 1'b1;
                        frame_start_d = 1'b1;
                    end else begin
                        gcnt_dec = 1'b1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            pat_q       <= DEFAULT_PAT;
            gap_len_q   <= '0;
            dout        <= 1'b0;
            dout_valid  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            gap_len_q   <= gap_len_d;
            dout        <= dout_d;
            dout_valid  <= dout_valid_d;
            frame_start <= frame_start_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_gen
// Self-checking bench for seq_pattern_gen. A cycle-indexed table of expected
// outputs is filled from the run rules and compared on every falling edge;
// directed literal vectors pin the table for the listed scenarios.
// -----------------------------------------------------------------------------
module tb_seq_pattern_gen;

    localparam int W    = 3;
    localparam int MAXC = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [2:0] pattern;
    logic [7:0] reps;
    logic [3:0] gap;
    logic       dout;
    logic       dout_valid;
    logic       frame_start;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Expected {dout, dout_valid, frame_start, busy, done} per cycle
    logic [4:0] exp_out [MAXC];

    seq_pattern_gen dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .pattern     (pattern),
        .reps        (reps),
        .gap         (gap),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Cycle n is the period following rising edge n
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void clear_from(input int c);
        for (int i = c; i < MAXC; i++) exp_out[i] = '0;
    endfunction

    // Lay out a whole run starting with the first bit in cycle n+1
    function automatic void model_run(input int n, input logic [2:0] p, input int r_in,
                                      input int g);
        int r;
        int c;
        r = (r_in == 0) ? 1 : r_in;
        c = n + 1;
        for (int f = 0; f < r; f++) begin
            for (int b = 0; b < W; b++) begin
                if (c < MAXC) exp_out[c] = {p[W-1-b], 1'b1, (b == 0), 1'b1, 1'b0};
                c++;
            end
            if (f < r - 1) begin
                for (int k = 0; k < g; k++) begin
                    if (c < MAXC) exp_out[c] = 5'b00010;
                    c++;
                end
            end
        end
        if (c < MAXC) exp_out[c] = 5'b00001;
    endfunction

    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            check($sformatf("cycle%0d_outputs", cyc),
                  {27'd0, dout, dout_valid, frame_start, busy, done}, {27'd0, exp_out[cyc]});
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Raise start for the current cycle; the model accepts it only when idle
    task automatic arm_start(input logic [2:0] p, input int r, input int g);
        start   = 1'b1;
        pattern = p;
        reps    = 8'(r);
        gap     = 4'(g);
        if (exp_out[cyc][1] == 1'b0) model_run(cyc, p, r, g);
    endtask

    task automatic do_start(input logic [2:0] p, input int r, input int g);
        arm_start(p, r, g);
        next_cycle();
        start = 1'b0;
    endtask

    task automatic arm_stop();
        stop = 1'b1;
        if (exp_out[cyc][1] == 1'b1) clear_from(cyc + 1);
    endtask

    task automatic cap(output logic [4:0] v);
        @(negedge clk);
        v = {dout, dout_valid, frame_start, busy, done};
        next_cycle();
    endtask

    task automatic idle(input int n);
        repeat (n) next_cycle();
    endtask

    logic [4:0] v;
    logic [8:0] bits;
    logic [8:0] fs_bits;
    logic [8:0] val_bits;
    logic [4:0] tab1 [4];
    logic [4:0] tab3 [9];

    initial begin
        tab1 = '{5'b11110, 5'b01010, 5'b11010, 5'b00001};
        tab3 = '{5'b11110, 5'b11010, 5'b01010, 5'b00010, 5'b00010,
                 5'b11110, 5'b11010, 5'b01010, 5'b00001};

        rst = 1'b1; start = 1'b0; stop = 1'b0;
        pattern = '0; reps = '0; gap = '0;
        clear_from(0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {27'd0, dout, dout_valid, frame_start, busy, done}, 32'd0);
        check("reset_pattern_reg", {29'd0, dut.pat_q}, 32'h5);
        chk_en = 1'b1;
        rst = 1'b0;

        // Single frame 101
        do_start(3'b101, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cap(v);
            check($sformatf("s1_cycle%0d", i + 1), {27'd0, v}, {27'd0, tab1[i]});
        end
        idle(2);

        // Three frames back-to-back
        do_start(3'b101, 3, 0);
        bits = '0; fs_bits = '0; val_bits = '0;
        for (int i = 0; i < 9; i++) begin
            cap(v);
            bits     = {bits[7:0], v[4]};
            val_bits = {val_bits[7:0], v[3]};
            fs_bits  = {fs_bits[7:0], v[2]};
        end
        check("s2_stream", {23'd0, bits}, {23'd0, 9'b101101101});
        check("s2_valid", {23'd0, val_bits}, {23'd0, 9'b111111111});
        check("s2_frame_start", {23'd0, fs_bits}, {23'd0, 9'b100100100});
        // Start held in the done cycle is accepted
        arm_start(3'b110, 1, 0);
        cap(v);
        check("s2_done_cycle10", {27'd0, v}, {27'd0, 5'b00001});
        start = 1'b0;
        cap(v);
        check("restart_first_bit", {27'd0, v}, {27'd0, 5'b11110});
        idle(4);

        // Two frames with a two-cycle gap
        do_start(3'b110, 2, 2);
        for (int i = 0; i < 9; i++) begin
            cap(v);
            check($sformatf("s3_cycle%0d", i + 1), {27'd0, v}, {27'd0, tab3[i]});
        end
        idle(2);

        // reps=0 acts as one frame; start while busy is ignored
        do_start(3'b101, 0, 0);
        cap(v);
        check("s4_cycle1", {27'd0, v}, {27'd0, tab1[0]});
        arm_start(3'b010, 5, 3);
        cap(v);
        check("s4_cycle2", {27'd0, v}, {27'd0, tab1[1]});
        start = 1'b0;
        for (int i = 2; i < 4; i++) begin
            cap(v);
            check($sformatf("s4_cycle%0d", i + 1), {27'd0, v}, {27'd0, tab1[i]});
        end
        cap(v);
        check("s4_cycle5_idle", {27'd0, v}, 32'd0);
        idle(2);

        // Abort in cycle 2 of a four-frame run, restart in cycle 5
        do_start(3'b101, 4, 0);
        cap(v);
        check("s5_cycle1", {27'd0, v}, {27'd0, 5'b11110});
        arm_stop();
        cap(v);
        check("s5_cycle2", {27'd0, v}, {27'd0, 5'b01010});
        stop = 1'b0;
        cap(v);
        check("s5_cycle3_stopped", {27'd0, v}, 32'd0);
        cap(v);
        check("s5_cycle4_stopped", {27'd0, v}, 32'd0);
        arm_start(3'b101, 1, 0);
        cap(v);
        check("s5_cycle5_idle", {27'd0, v}, 32'd0);
        start = 1'b0;
        cap(v);
        check("s5_cycle6_first_bit", {27'd0, v}, {27'd0, 5'b11110});
        idle(4);

        // Model-only runs: max gap, stop inside a gap
        do_start(3'b011, 2, 15);
        idle(24);
        do_start(3'b100, 5, 1);
        idle(22);
        do_start(3'b101, 3, 3);
        idle(4);
        arm_stop();
        next_cycle();
        stop = 1'b0;
        idle(6);

        // Asynchronous reset in the middle of a frame
        do_start(3'b110, 3, 0);
        idle(2);
        #1;
        rst = 1'b1;
        clear_from(0);
        #1;
        check("async_rst_outputs", {27'd0, dout, dout_valid, frame_start, busy, done}, 32'd0);
        next_cycle();
        rst = 1'b0;
        check("async_rst_pattern_reg", {29'd0, dut.pat_q}, 32'h5);
        do_start(3'b101, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cap(v);
            check($sformatf("s6_cycle%0d", i + 1), {27'd0, v}, {27'd0, tab1[i]});
        end
        idle(3);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
